// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by uart_rx and uart_tx.
// Holds the FSM state encoding, DATA_BITS and the clocks-per-bit helper.
`timescale 1ns/1ps
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchronizer for the async RX line plus armed
// falling-edge detect.
// Ports: CLK, rst (sync, active-high), rx_i (async line),
//   clr_i (disarm while the receiver is busy), rx_o (synchronized
//   line), fall_o (armed 1->0 transition seen).
`timescale 1ns/1ps
module uart_rx_sync (
  input  logic CLK,
  input  logic rst,
  input  logic rx_i,
  input  logic clr_i,
  output logic rx_o,
  output logic fall_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic armed_q, armed_d;

  // armed_q means the synchronized line has been high since the
  // receiver last went idle; a low line while armed is a real edge.
  always_comb begin
    meta_d  = rx_i;
    sync_d  = meta_q;
    armed_d = armed_q;
    if (clr_i) begin
      armed_d = 1'b0;
    end else if (sync_q) begin
      armed_d = 1'b1;
    end else begin
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      armed_q <= armed_d;
    end
  end

  assign rx_o   = sync_q;
  assign fall_o = armed_q & ~sync_q & ~clr_i;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8N1 by default, 8E1 when UART_RX_PARITY_EN
// is defined. Ports: CLK, rst (sync, active-high), RX (async line),
//   full (downstream fifo full), data/wr (byte + write strobe),
//   frame_err, parity_err, overrun (one-cycle pulses), rx_active.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 RX,
  input  logic                 full,
  output logic [DATA_BITS-1:0] data,
  output logic                 wr,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 rx_active
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);

  if (CPB < 4) begin : g_cpb_check
    $error("uart_rx: CLK_FREQ/BAUD must be at least 4");
  end

  uart_state_e state_q, state_d;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 wr_q, wr_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 pe_q, pe_d;
  logic                 pbad_q, pbad_d;
  logic                 rx_s;
  logic                 fall;
  logic                 busy;

  assign busy = (state_q != IDLE);

  uart_rx_sync u_sync (
    .CLK    (CLK),
    .rst    (rst),
    .rx_i   (RX),
    .clr_i  (busy),
    .rx_o   (rx_s),
    .fall_o (fall)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    fe_d    = 1'b0;
    ov_d    = 1'b0;
    pe_d    = 1'b0;
    pbad_d  = pbad_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          // A line back high by mid-bit is a glitch.
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          pbad_d  = rx_s ^ (^shift_q);
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          data_d  = shift_q;
          if (!rx_s) begin
            fe_d = 1'b1;
          end else if (pbad_q) begin
            pe_d = 1'b1;
          end else if (full) begin
            ov_d = 1'b1;
          end else begin
            wr_d = 1'b1;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      pe_q    <= 1'b0;
      pbad_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
      pe_q    <= pe_d;
      pbad_q  <= pbad_d;
    end
  end

  assign data      = data_q;
  assign wr        = wr_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
  assign rx_active = busy;

`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx at 104 clocks/bit.
// Stimulus pushes the expected strobe; a monitor pops on every strobe.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 104;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [3:0] K_WR = 4'b1000;
  localparam logic [3:0] K_FE = 4'b0100;
  localparam logic [3:0] K_PE = 4'b0010;
  localparam logic [3:0] K_OV = 4'b0001;

  logic       CLK = 1'b0;
  logic       rst;
  logic       RX;
  logic       full;
  logic [7:0] data;
  logic       wr;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;
  logic       rx_active;

  uart_rx #(
    .CLK_FREQ (12000000),
    .BAUD     (115200)
  ) dut (
    .CLK        (CLK),
    .rst        (rst),
    .RX         (RX),
    .full       (full),
    .data       (data),
    .wr         (wr),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .rx_active  (rx_active)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] kind;
    logic [7:0] byte_v;
  } exp_t;

  exp_t  q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  string hello    = "Hello World!\r\n";

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: outcome of one frame from its contents and full.
  function automatic exp_t model(logic [7:0] b, bit stop_ok,
                                 bit par_bad, bit full_v);
    exp_t e;
    e.byte_v = b;
    if (!stop_ok)                e.kind = K_FE;
    else if (PAR_EN && par_bad)  e.kind = K_PE;
    else if (full_v)             e.kind = K_OV;
    else                         e.kind = K_WR;
    return e;
  endfunction

  task automatic hold(logic v, int n);
    RX = v;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send(logic [7:0] b, bit stop_ok, bit par_bad);
    q.push_back(model(b, stop_ok, par_bad, full));
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    if (PAR_EN) hold((^b) ^ par_bad, CPB);
    hold(stop_ok, CPB);
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_wr"}, wr, 0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_perr"}, parity_err, 0);
    chk({tag, "_ovr"}, overrun, 0);
    chk({tag, "_act"}, rx_active, 0);
  endtask

  always @(negedge CLK) begin : mon
    logic [3:0] k;
    exp_t       e;
    k = {wr, frame_err, parity_err, overrun};
    if (k != 4'b0000) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", k, 0);
      end else begin
        e = q.pop_front();
        chk("strobe_kind", k, e.kind);
        if (e.kind == K_WR) chk("wr_data", data, e.byte_v);
      end
    end
  end

  initial begin
    logic [7:0] b;
    bit         s_ok;
    bit         pb;
    rst  = 1'b1;
    RX   = 1'b1;
    full = 1'b0;
    repeat (3) @(negedge CLK);
    chk_quiet("reset");
    rst = 1'b0;
    hold(1'b1, 20);
    chk("idle_act", rx_active, 0);

    send(8'h48, 1'b1, 1'b0);
    chk("act_after_48", rx_active, 0);
    hold(1'b1, 50);

    for (int i = 0; i < hello.len(); i++) send(hello[i], 1'b1, 1'b0);
    hold(1'b1, 50);

    hold(1'b0, 10);
    chk("glitch_act_hi", rx_active, 1);
    hold(1'b0, 20);
    hold(1'b1, 30);
    chk("glitch_act_lo", rx_active, 0);
    hold(1'b1, 20);

    send(8'h55, 1'b0, 1'b0);
    hold(1'b0, 300);
    chk("break_act", rx_active, 0);
    hold(1'b1, CPB);
    send(8'h0A, 1'b1, 1'b0);
    hold(1'b1, 20);

    full = 1'b1;
    send(8'h21, 1'b1, 1'b0);
    full = 1'b0;
    hold(1'b1, 20);
    send(8'h6C, 1'b1, 1'b0);
    hold(1'b1, 20);

    b = 8'h6F;
    hold(1'b0, CPB);
    for (int i = 0; i < 3; i++) hold(b[i], CPB);
    hold(b[3], CPB / 2);
    rst = 1'b1;
    RX  = 1'b1;
    @(negedge CLK);
    chk_quiet("midrst");
    rst = 1'b0;
    hold(1'b1, CPB);
    send(8'h0D, 1'b1, 1'b0);
    hold(1'b1, 20);

    if (PAR_EN) begin
      send(8'h6F, 1'b1, 1'b1);
      hold(1'b1, 20);
    end

    for (int n = 0; n < 24; n++) begin
      b    = 8'($urandom);
      full = ($urandom % 4) == 0;
      s_ok = ($urandom % 8) != 0;
      pb   = PAR_EN && (($urandom % 4) == 0);
      send(b, s_ok, pb);
      full = 1'b0;
      if (!s_ok) begin
        hold(1'b0, $urandom_range(0, 200));
        hold(1'b1, CPB);
      end else begin
        hold(1'b1, $urandom_range(0, 150));
      end
    end

    for (int i = 0; i < 2000 && q.size() > 0; i++) @(negedge CLK);
    chk("queue_drained", q.size(), 0);
    hold(1'b1, 300);
    chk("final_act", rx_active, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
